ahb_master_if: RTL and testbench

//  AHB master engine directly downstream of the APB-programmed DMA controller.

---
 rtl/ahb_master_if.sv | 120 ++++++++++++
 tb/tb_ahb_master_if.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_if.sv
// ahb_master_if: runs one DMA transfer command as an AHB master with arbitration,
// 1KB burst restart, wait states, grant loss and error termination.
module ahb_master_if #(
  parameter int LEN_W = 10,
  parameter int BND_W = 10
) (
  input  logic             CLk,
  input  logic             RST,
  input  logic             Start,
  input  logic             WR,
  input  logic [31:0]      WRAddr,
  input  logic [2:0]       WRSize,
  input  logic [LEN_W-1:0] WRLen,
  input  logic             WRBurst,
  input  logic             Lock,
  input  logic [31:0]      Din,
  output logic             ReadEn,
  output logic             DoutVld,
  output logic [31:0]      Dout,
  output logic             Done,
  output logic             Err,
  output logic             Busy,
  output logic             HBUSREQ,
  output logic             HLOCK,
  input  logic             HGRANT,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [1:0]       HRESP,
  input  logic [31:0]      HRDATA
);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, XFER = 3'd2, DRAIN = 3'd3, FIN = 3'd4;
  logic [2:0] state, sizeReg;
  logic [LEN_W:0] len, addrCnt, addrCntNext;
  logic [31:0] addr;
  logic wrReg, burstReg, dPend, needNs, errReg;
  logic respErr, drive, accept, more, dPendNext, dataOk;
  always_comb begin
    respErr = dPend && HRESP != 2'b00;
    drive = !respErr && ((state == REQ && HGRANT) || (state == XFER && addrCnt < len));
    accept = drive && HREADY;
    addrCntNext = addrCnt + {{LEN_W{1'b0}}, accept};
    more = addrCntNext < len;
    dPendNext = accept || (dPend && !HREADY);
    dataOk = dPend && HREADY && !respErr;
  end
  // NONSEQ on the first beat after (re)arbitration, in SINGLE mode, and at each 2^BND_W boundary
  assign HTRANS = drive ? ((needNs || !burstReg || addr[BND_W-1:0] == '0) ? 2'b10 : 2'b11) : 2'b00;
  assign HBUSREQ = state == REQ || ((state == XFER || state == DRAIN) && addrCnt < len && !respErr);
  assign HLOCK = state != IDLE && Lock;
  assign HADDR = addr;
  assign HWRITE = wrReg;
  assign HSIZE = sizeReg;
  assign HBURST = {2'b00, burstReg};
  assign HWDATA = (dPend && wrReg) ? Din : '0;
  assign ReadEn = accept && wrReg;
  assign Busy = state != IDLE;
  assign Done = state == FIN;
  assign Err = Done && errReg;
  always_ff @(posedge CLk) begin
    if (RST) begin
      state <= IDLE;
      sizeReg <= '0;
      len <= '0;
      addrCnt <= '0;
      addr <= '0;
      wrReg <= 1'b0;
      burstReg <= 1'b0;
      dPend <= 1'b0;
      needNs <= 1'b0;
      errReg <= 1'b0;
      DoutVld <= 1'b0;
      Dout <= '0;
    end else begin
      DoutVld <= dataOk && !wrReg;
      if (dataOk && !wrReg) Dout <= HRDATA;
      if (accept) begin
        addr <= addr + (32'd1 << sizeReg);
        needNs <= 1'b0;
      end
      addrCnt <= addrCntNext;
      dPend <= dPendNext;
      case (state)
        IDLE: if (Start) begin
          state <= REQ;
          addr <= WRAddr;
          sizeReg <= WRSize;
          wrReg <= WR;
          burstReg <= WRBurst;
          len <= (WRLen == '0) ? {{LEN_W{1'b0}}, 1'b1} : {1'b0, WRLen};
          addrCnt <= '0;
          needNs <= 1'b1;
          errReg <= 1'b0;
        end
        REQ: if (accept) state <= XFER;
        XFER: begin
          if (respErr && HREADY) begin
            state <= FIN;
            errReg <= 1'b1;
          end else if (HREADY && !HGRANT && more) state <= DRAIN;
          else if (!more && !dPendNext) state <= FIN;
        end
        DRAIN: begin
          if (respErr && HREADY) begin
            state <= FIN;
            errReg <= 1'b1;
          end else if (!dPendNext) begin
            state <= REQ;
            needNs <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_master_if.sv
// tb_ahb_master_if: table of transfer commands run against a behavioural AHB slave,
// with expected beats and read data queued and compared as the DUT produces them.
module tb_ahb_master_if;
  logic CLk = 0, RST = 1, Start = 0, WR = 0, WRBurst = 0, Lock = 0;
  logic [31:0] WRAddr = 0, Din = 0;
  logic [2:0] WRSize = 0;
  logic [9:0] WRLen = 0;
  logic HGRANT = 1, HREADY = 1;
  logic [1:0] HRESP = 0;
  logic [31:0] HRDATA = 0;
  logic ReadEn, DoutVld, Done, Err, Busy, HBUSREQ, HLOCK, HWRITE;
  logic [31:0] Dout, HADDR, HWDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE, HBURST;
  int total = 0, bad = 0;

  ahb_master_if dut (
    .CLk(CLk), .RST(RST), .Start(Start), .WR(WR), .WRAddr(WRAddr), .WRSize(WRSize),
    .WRLen(WRLen), .WRBurst(WRBurst), .Lock(Lock), .Din(Din), .ReadEn(ReadEn),
    .DoutVld(DoutVld), .Dout(Dout), .Done(Done), .Err(Err), .Busy(Busy),
    .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HGRANT(HGRANT), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 CLk = ~CLk;

  typedef struct {
    logic wr; logic [31:0] addr; logic [2:0] size; logic [9:0] len; logic burst; logic lock;
    int waitBeat; int errBeat; int gdrop; logic spur;
    int expBeats; int expVld; logic expErr;
  } vec_t;
  vec_t vecs[8];
  logic [63:0] expQ[$];
  logic [31:0] rdQ[$];

  function automatic logic [31:0] rd(input int i, input logic [31:0] b);
    return 32'hA5A5_0000 ^ (b + 32'(i) * 32'h0001_0003);
  endfunction

  function automatic logic [31:0] wd(input int i);
    return 32'h5A00_0011 + 32'(i) * 32'h0102_0304;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s act=unexpected exp=none", name);
  endtask

  task automatic idleChk(input string name);
    chk({name, "_ctl"}, {HTRANS, HBUSREQ, Busy, Done, DoutVld, HLOCK, ReadEn, Err}, 64'd0);
    chk({name, "_haddr"}, HADDR, 64'd0);
    chk({name, "_dout"}, Dout, 64'd0);
    chk({name, "_hwdata"}, HWDATA, 64'd0);
  endtask

  task automatic run(input vec_t v);
    int cyc = 0, acc = 0, reCnt = 0, vldCnt = 0, doneCnt = 0, lastEnd = -10;
    int dBeat = 0, waitLeft = 2, errPh = 0, gLow = 0;
    logic dValid = 0, reSeen = 0, dropped = 0, stall = 0, accNow, endNow;
    logic [31:0] a, prevAddr = 0;
    logic [1:0] prevTrans = 0;
    logic [9:0] n;
    n = (v.len == 0) ? 10'd1 : v.len;
    a = v.addr;
    expQ.delete();
    rdQ.delete();
    for (int i = 0; i < int'(n); i++) begin
      if (v.errBeat < 0 || i <= v.errBeat)
        expQ.push_back({a, (i == 0 || !v.burst || a[9:0] == 10'd0 || i == v.gdrop) ? 2'b10 : 2'b11,
                        v.wr, v.size, v.burst ? 3'b001 : 3'b000});
      a += 32'd1 << v.size;
    end
    while (doneCnt == 0 && cyc < 200) begin
      @(negedge CLk);
      Start = (cyc == 0) || (v.spur && cyc == 3);
      if (cyc == 0) begin
        WR = v.wr; WRAddr = v.addr; WRSize = v.size; WRLen = v.len; WRBurst = v.burst;
      end else if (Start) begin
        WR = ~v.wr; WRAddr = 32'hDEAD_0000; WRLen = 10'd9;
      end
      Lock = v.lock;
      if (reSeen) Din = wd(reCnt - 1);
      if (!dropped && v.gdrop > 0 && cyc > 0 && acc == v.gdrop - 1) begin
        dropped = 1;
        gLow = 3;
      end
      HGRANT = (gLow == 0);
      if (gLow > 0) gLow--;
      if (dValid && dBeat == v.errBeat) begin
        HREADY = (errPh == 1);
        HRESP = 2'b01;
      end else if (dValid && dBeat == v.waitBeat && waitLeft > 0) begin
        HREADY = 0;
        HRESP = 0;
        waitLeft--;
      end else begin
        HREADY = 1;
        HRESP = 0;
      end
      HRDATA = dValid ? rd(dBeat, v.addr) : 32'd0;
      #1;
      accNow = HTRANS != 2'b00 && HREADY;
      endNow = dValid && HREADY;
      if (cyc == 1) chk("req_lat", {Busy, HBUSREQ, HTRANS}, {2'b11, 2'b10});
      chk("hlock", HLOCK, v.lock && cyc > 0);
      if (ReadEn || (accNow && v.wr)) chk("readen", ReadEn, accNow && v.wr);
      if (dValid && v.wr) chk("hwdata", HWDATA, wd(dBeat));
      if (stall) chk("addr_frozen", {HADDR, HTRANS}, {prevAddr, prevTrans});
      if (dValid && HRESP != 0) chk("err_idle", HTRANS, 2'b00);
      if (accNow) begin
        if (expQ.size() == 0) miss("extra_beat");
        else chk("beat", {HADDR, HTRANS, HWRITE, HSIZE, HBURST}, expQ.pop_front());
        acc++;
      end
      if (DoutVld) begin
        if (rdQ.size() == 0) miss("extra_doutvld");
        else chk("dout", Dout, rdQ.pop_front());
        vldCnt++;
      end
      if (Done) begin
        doneCnt++;
        chk("err", Err, v.expErr);
        chk("done_lat", cyc, lastEnd + 1);
        if (!v.wr && !v.expErr) chk("last_vld", DoutVld, 1);
      end
      if (ReadEn) reCnt++;
      reSeen = ReadEn;
      if (endNow) begin
        if (HRESP == 0 && !v.wr) rdQ.push_back(rd(dBeat, v.addr));
        lastEnd = cyc;
      end
      if (dValid && HRESP != 0) errPh++;
      stall = HTRANS != 0 && !HREADY && HRESP == 0;
      prevAddr = HADDR;
      prevTrans = HTRANS;
      if (HREADY) begin
        dValid = accNow;
        dBeat = acc - 1;
      end
      cyc++;
    end
    if (doneCnt == 0) begin
      total++;
      bad++;
      $display("FAIL timeout act=no_done exp=done");
    end
    chk("beats", acc, v.expBeats);
    chk("vld_cnt", vldCnt, v.expVld);
    chk("readen_cnt", reCnt, v.wr ? v.expBeats : 0);
    Start = 0; Lock = 0; HGRANT = 1; HREADY = 1; HRESP = 0;
    repeat (3) begin
      @(negedge CLk);
      #1;
      chk("idle_after", {Busy, Done, HTRANS, HBUSREQ}, 64'd0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h100, 3'd2, 10'd4, 1'b1, 1'b0, -1, -1, 0, 1'b0, 4, 4, 1'b0};
    vecs[1] = '{1'b1, 32'h200, 3'd2, 10'd3, 1'b1, 1'b0,  1, -1, 0, 1'b0, 3, 0, 1'b0};
    vecs[2] = '{1'b0, 32'h3F8, 3'd2, 10'd4, 1'b1, 1'b0, -1, -1, 0, 1'b0, 4, 4, 1'b0};
    vecs[3] = '{1'b1, 32'h040, 3'd2, 10'd6, 1'b1, 1'b1, -1, -1, 2, 1'b0, 6, 0, 1'b0};
    vecs[4] = '{1'b0, 32'h020, 3'd2, 10'd4, 1'b1, 1'b0, -1,  1, 0, 1'b0, 2, 1, 1'b1};
    vecs[5] = '{1'b0, 32'h010, 3'd0, 10'd3, 1'b0, 1'b0, -1, -1, 0, 1'b1, 3, 3, 1'b0};
    vecs[6] = '{1'b1, 32'h002, 3'd1, 10'd0, 1'b1, 1'b0, -1, -1, 0, 1'b0, 1, 0, 1'b0};
    vecs[7] = '{1'b1, 32'h3FC, 3'd1, 10'd3, 1'b1, 1'b1, -1,  2, 0, 1'b0, 3, 0, 1'b1};
    repeat (2) @(negedge CLk);
    #1;
    idleChk("reset");
    RST = 0;
    Lock = 1; WR = 0; WRAddr = 32'h80; WRSize = 3'd2; WRLen = 10'd8; WRBurst = 1;
    HRDATA = 32'h1234_5678;
    @(negedge CLk);
    Start = 1;
    @(negedge CLk);
    Start = 0;
    repeat (3) @(negedge CLk);
    RST = 1;
    @(negedge CLk);
    #1;
    idleChk("mid_rst");
    RST = 0;
    Lock = 0;
    repeat (4) begin
      @(negedge CLk);
      #1;
      chk("no_done", {Done, Busy}, 64'd0);
    end
    for (int i = 0; i < 8; i++) run(vecs[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
